// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Purpose  : UART transmit framer; serialises a latched word LSB-first as
//            start / data / optional parity / 1-2 stop bits, one bit per
//            rising edge of the baud square wave.
// Revision : 1.0
// ============================================================================
module uart_tx_frame #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_clk,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int               CNT_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t                 state_q,    state_d;
    logic                   baud_q;
    logic [DATA_BITS-1:0]   shadow_q,   shadow_d;
    logic                   par_bit_q,  par_bit_d;
    logic                   par_en_q,   par_en_d;
    logic                   two_stop_q, two_stop_d;
    logic [CNT_W-1:0]       bit_cnt_q,  bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   tx_q,       tx_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;

    logic                   w_tick;
    logic [CNT_W-1:0]       w_next_idx;

    // One tick per rising edge of the baud square wave marks a bit boundary.
    assign w_tick     = baud_clk & ~baud_q;
    assign w_next_idx = bit_cnt_q + c_CNT_ONE;

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        par_bit_d  = par_bit_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    shadow_d   = tx_data;
                    par_bit_d  = (^tx_data) ^ parity_odd;
                    par_en_d   = parity_en;
                    two_stop_d = two_stop;
                    busy_d     = 1'b1;
                    state_d    = S_SYNC;
                end
            end

            // Hold the line high until a fresh bit boundary so the start bit
            // is always a full bit time.
            S_SYNC: begin
                tx_d = 1'b1;
                if (w_tick) begin
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (w_tick) begin
                    tx_d      = shadow_q[0];
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end

            S_DATA: begin
                if (w_tick) begin
                    if (bit_cnt_q < c_LAST_BIT) begin
                        bit_cnt_d = w_next_idx;
                        tx_d      = shadow_q[w_next_idx];
                    end else if (par_en_q) begin
                        tx_d    = par_bit_q;
                        state_d = S_PARITY;
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = S_STOP;
                    end
                end
            end

            S_PARITY: begin
                if (w_tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
            end

            S_STOP: begin
                tx_d = 1'b1;
                if (w_tick) begin
                    if (two_stop_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            baud_q     <= 1'b0;
            shadow_q   <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_clk;
            shadow_q   <= shadow_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Purpose  : Self-checking bench for uart_tx_frame; a frame is predicted as a
//            list of line levels, each held for one 16-clk bit time.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_frame;

    localparam int BIT_CLK = 16;

    logic       clk;
    logic       reset;
    logic       baud_clk;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       parity_en;
    logic       parity_odd;
    logic       two_stop;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int  n_assert = 0;
    int  n_fail   = 0;
    bit  baud_freeze = 0;
    int  bcnt = 0;
    time rise_t = 0;

    uart_tx_frame #(.DATA_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_clk   (baud_clk),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud square wave: toggles every 8 clk unless frozen.
    initial begin
        baud_clk = 1'b0;
        forever begin
            @(negedge clk);
            if (!baud_freeze) begin
                bcnt++;
                if (bcnt == BIT_CLK / 2) begin
                    bcnt     = 0;
                    baud_clk = ~baud_clk;
                    if (baud_clk) rise_t = $time;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [7:0] d, input bit pen, input bit podd, input bit ts);
        @(negedge clk);
        tx_start   = 1'b1;
        tx_data    = d;
        parity_en  = pen;
        parity_odd = podd;
        two_stop   = ts;
        @(posedge clk);
        #1 tx_start = 1'b0;
    endtask

    // Follows one frame from the cycle after acceptance to the tx_done cycle.
    // Returns with the current time inside the tx_done cycle.
    task automatic check_frame(input logic [7:0] d, input bit pen, input bit podd,
                               input bit ts, input int freeze_bit, output int waits);
        logic lvl[$];
        bit   fell;
        bit   ones_odd;
        lvl = {};
        lvl.push_back(1'b0);
        for (int i = 0; i < 8; i++) lvl.push_back(d[i]);
        ones_odd = ($countones(d) % 2) == 1;
        if (pen) lvl.push_back(podd ? !ones_odd : ones_odd);
        lvl.push_back(1'b1);
        if (ts) lvl.push_back(1'b1);

        waits = 0;
        fell  = 0;
        while (!fell && waits < 64) begin
            @(negedge clk);
            if (tx === 1'b0) fell = 1;
            else begin
                waits++;
                chk("sync_busy", tx_busy, 1);
            end
        end
        chk("start_seen", fell, 1);
        if (!fell) return;
        chk("start_align", 32'($time - rise_t), 10);

        for (int b = 0; b < lvl.size(); b++) begin
            for (int c = 0; c < BIT_CLK; c++) begin
                if (!(b == 0 && c == 0)) @(negedge clk);
                chk("frame_bit", tx, lvl[b]);
                chk("frame_busy", tx_busy, 1);
                chk("frame_done", tx_done, 0);
                if (b == freeze_bit && c == 4) begin
                    @(posedge clk);
                    baud_freeze = 1;
                    repeat (200) begin
                        @(negedge clk);
                        chk("freeze_tx", tx, lvl[b]);
                        chk("freeze_busy", tx_busy, 1);
                    end
                    @(posedge clk);
                    baud_freeze = 0;
                end
            end
        end
        @(negedge clk);
        chk("end_done", tx_done, 1);
        chk("end_busy", tx_busy, 0);
        chk("end_tx", tx, 1);
    endtask

    initial begin
        int         w;
        logic [7:0] d;
        bit         pen, podd, ts;

        reset      = 1'b0;
        tx_start   = 1'b0;
        tx_data    = 8'h00;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_tx", tx, 1);
        chk("idle_busy", tx_busy, 0);
        chk("idle_done", tx_done, 0);

        // Plain 8N1 frame
        request(8'hA5, 0, 0, 0);
        check_frame(8'hA5, 0, 0, 0, -1, w);

        // Parity even / odd / two stop bits
        request(8'h07, 1, 0, 0);
        check_frame(8'h07, 1, 0, 0, -1, w);
        request(8'h07, 1, 1, 0);
        check_frame(8'h07, 1, 1, 0, -1, w);
        request(8'h07, 1, 1, 1);
        check_frame(8'h07, 1, 1, 1, -1, w);

        // Request held high through a frame with different data and config
        request(8'h3C, 0, 0, 0);
        tx_start   = 1'b1;
        tx_data    = 8'hFF;
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        two_stop   = 1'b1;
        check_frame(8'h3C, 0, 0, 0, -1, w);
        @(posedge clk);
        #1 tx_start = 1'b0;
        check_frame(8'hFF, 1, 1, 1, -1, w);
        chk("held_gap", (w + 1 >= BIT_CLK), 1);

        // Back-to-back request issued in the tx_done cycle
        tx_start   = 1'b1;
        tx_data    = 8'h81;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        @(posedge clk);
        #1 tx_start = 1'b0;
        check_frame(8'h81, 0, 0, 0, -1, w);
        chk("b2b_gap", (w + 1 >= BIT_CLK), 1);

        // Baud frozen during data bit 4
        request(8'h5A, 1, 0, 0);
        check_frame(8'h5A, 1, 0, 0, 5, w);

        // Asynchronous reset during data bit 3
        request(8'hC9, 0, 0, 0);
        w = 0;
        while (tx !== 1'b0 && w < 64) begin
            @(negedge clk);
            w++;
        end
        chk("abort_start", tx, 0);
        repeat (BIT_CLK * 4 + 5) @(negedge clk);
        d = 8'hC9;
        chk("abort_bit3", tx, d[3]);
        #2 reset = 1'b0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", tx_busy, 0);
        chk("abort_done", tx_done, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        request(8'h96, 1, 1, 0);
        check_frame(8'h96, 1, 1, 0, -1, w);

        // Random frames with random idle gaps
        for (int k = 0; k < 10; k++) begin
            d    = 8'($urandom);
            pen  = 1'($urandom);
            podd = 1'($urandom);
            ts   = 1'($urandom);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            request(d, pen, podd, ts);
            check_frame(d, pen, podd, ts, -1, w);
        end

        repeat (5) @(negedge clk);
        chk("final_idle_tx", tx, 1);
        chk("final_idle_busy", tx_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
